tick_pwm_gen: RTL and testbench
===============================

Name: tick_pwm_gen

Overview:
- Downstream consumer of the clock-divider stage: samples the divider's `clk_out` level in the system clock domain and rising-edge detects it into a one-cycle tick.
- Uses that tick as the time base for a programmable PWM output.
- Period and duty are loaded through a valid/ready handshake into a shadow register. They take effect only at a period boundary, so the output never glitches mid-period.

Parameters:
- WIDTH, 8, width of the period, duty and tick counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- div_clk  input  1  divider output level, synchronous to clk.
- en  input  1  run enable.
- cfg_valid  input  1  period_in/duty_in valid.
- cfg_ready  output  1  shadow register free.
- period_in  input  WIDTH  period minus one, in ticks.
- duty_in  input  WIDTH  high time, in ticks.
- pwm_out  output  1  PWM waveform.
- period_end  output  1  one-cycle pulse at each completed period.
- running  output  1  high in RUN state.

Behaviour:
- Reset (rst=0, asynchronous):
  - div_q, cnt, per_r, duty_r, pend_per and pend_duty = 0.
  - pend_v = 0, act_v = 0, state = IDLE.
  - Outputs: pwm_out=0, period_end=0, running=0, cfg_ready=1.
  - Reset mid-period aborts immediately; all configuration is lost.
- Tick generation:
  - div_q <= div_clk.
  - tick = div_clk & ~div_q (combinational), so one tick per divider rising edge.
  - div_clk held high produces no further ticks.
- Handshake:
  - cfg_ready = ~pend_v.
  - On cfg_valid & cfg_ready at a clk edge: pend_per <= period_in, pend_duty <= duty_in, pend_v <= 1.
  - cfg_valid while cfg_ready=0 is ignored; the source must hold its data.
- States: IDLE, RUN.
- IDLE:
  - cnt=0, pwm_out=0, running=0.
  - If en & (pend_v | act_v), go to RUN next edge.
  - On that entry, if pend_v: per_r <= pend_per, duty_r <= pend_duty, act_v <= 1, pend_v <= 0. Otherwise keep the retained active config.
- RUN, on a tick:
  - If cnt == per_r: cnt <= 0 and period_end <= 1 for the next cycle. If pend_v, load per_r/duty_r from pending and clear pend_v.
  - Otherwise cnt <= cnt + 1.
  - With no tick, cnt holds.
- RUN, en = 0: go to IDLE next edge, cnt <= 0. Active config is retained; a pending config stays pending.
- period_end is registered and high for exactly one clk cycle per boundary. It is also 0 in IDLE.
- pwm_out = running & (cnt < duty_r):
  - Compare is unsigned, full WIDTH.
  - duty_r = 0 gives constant low.
  - duty_r > per_r gives constant high.
  - Period length is per_r + 1 ticks; per_r = 0 gives a 1-tick period.
- Handshake and boundary in the same cycle: the boundary samples the old pend_v (0). The new config is captured into pending and applied at the following boundary.
- cnt never exceeds per_r. There is no wrap-around beyond per_r because the compare is equality against a config that can only change at a boundary.
- running = (state == RUN), registered.

Decomposition:
- Shared package `pwm_pkg`:
  - state enum {IDLE, RUN}.
  - default WIDTH constant.
- Sub-module `rise_det` (clk, rst, d, pulse): the div_q register plus the AND-NOT, reusable by other stages consuming the divider.

Test Plan:
- Reset and IDLE: rst=0 for 50 ns, div_clk toggling, en=1 with no config → pwm_out=0, period_end=0, running=0, cfg_ready=1 throughout. Assert rst=0 mid-run → all outputs 0 within the same cycle.
- Basic PWM: div_clk toggles every 5 clk (tick every 10 clk); load period_in=3, duty_in=2; en=1 → pwm_out high 20 clk, low 20 clk, repeating. period_end pulses exactly every 40 clk, one cycle wide.
- Boundary-only update: while running 3/2, handshake period_in=1, duty_in=1 mid-period → current period finishes at 20/20. Then 10 high / 10 low, and cfg_ready returns to 1 on the load.
- Backpressure: two back-to-back cfg_valid cycles → second is refused (cfg_ready=0). The first pending config is applied at the next boundary; the second is applied only after the source re-presents it.
- Duty extremes: duty_in=0 → pwm_out constant 0. duty_in=5 with period_in=3 → constant 1. period_in=0, duty_in=1 → constant 1 with period_end every tick.
- Enable drop and resume: en=0 mid-period → next cycle running=0, pwm_out=0, cnt=0. en=1 with no new config → restarts from cnt=0 with the retained 3/2 config.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the tick-driven PWM stage: controller states and default width.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for a level already synchronous to clk; one-cycle pulse per 0->1 transition.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/tick_pwm_gen.sv
// PWM generator timed by divider ticks; period/duty arrive via a valid/ready shadow register
// and are applied only at IDLE->RUN entry or at a period boundary.
module tick_pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out,
  output logic             period_end,
  output logic             running
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  pwm_state_e       state;
  pwm_state_e       state_nxt;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] per_r;
  logic [WIDTH-1:0] duty_r;
  logic [WIDTH-1:0] pend_per;
  logic [WIDTH-1:0] pend_duty;
  logic             pend_v;
  logic             act_v;
  logic             accept;
  logic             load_act;
  logic             pe_nxt;

  rise_det u_rise_det (
    .clk   (clk),
    .rst   (rst),
    .d     (div_clk),
    .pulse (tick)
  );

  assign cfg_ready = ~pend_v;
  assign accept    = cfg_valid & ~pend_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_act  = 1'b0;
    pe_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en && (pend_v || act_v)) begin
          state_nxt = RUN;
          load_act  = pend_v;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt == per_r) begin
            cnt_nxt  = '0;
            pe_nxt   = 1'b1;
            load_act = pend_v;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A load only happens with pend_v set, which blocks acceptance, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      per_r      <= '0;
      duty_r     <= '0;
      pend_per   <= '0;
      pend_duty  <= '0;
      pend_v     <= 1'b0;
      act_v      <= 1'b0;
      period_end <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      period_end <= pe_nxt;
      if (load_act) begin
        per_r  <= pend_per;
        duty_r <= pend_duty;
        act_v  <= 1'b1;
      end
      if (accept) begin
        pend_per  <= period_in;
        pend_duty <= duty_in;
        pend_v    <= 1'b1;
      end else if (load_act) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign running = (state == RUN);
  assign pwm_out = running & (cnt < duty_r);

  cnt_in_range: assert property (@(posedge clk) disable iff (!rst) cnt <= per_r);

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Scoreboard bench for tick_pwm_gen: a period/position model predicts every cycle's outputs.
module tb_tick_pwm_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       div_clk = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] period_in = '0;
  logic [7:0] duty_in = '0;
  logic       cfg_ready;
  logic       pwm_out;
  logic       period_end;
  logic       running;

  tick_pwm_gen #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_clk    (div_clk),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .period_in  (period_in),
    .duty_in    (duty_in),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pwm;
    bit pe;
    bit run;
    bit rdy;
  } exp_t;

  typedef struct {
    int per;
    int duty;
  } cfg_t;

  exp_t exp_q[$];
  cfg_t pend_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the current period, measured in ticks.
  bit m_run;
  int m_pos;
  int m_per;
  int m_duty;
  bit m_act;
  bit m_prev;
  bit m_pe;

  task automatic model_reset();
    m_run  = 0;
    m_pos  = 0;
    m_per  = 0;
    m_duty = 0;
    m_act  = 0;
    m_prev = 0;
    m_pe   = 0;
    pend_q.delete();
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pwm = m_run && (m_pos < m_duty);
    e.pe  = m_pe;
    e.run = m_run;
    e.rdy = (pend_q.size() == 0);
    return e;
  endfunction

  task automatic apply_pending();
    cfg_t c;
    c      = pend_q.pop_front();
    m_per  = c.per;
    m_duty = c.duty;
    m_act  = 1;
  endtask

  task automatic model_step();
    bit   tick;
    bit   accept;
    cfg_t c;
    tick   = div_clk && !m_prev;
    accept = cfg_valid && (pend_q.size() == 0);
    m_pe   = 0;
    if (!m_run) begin
      if (en && (pend_q.size() > 0 || m_act)) begin
        m_run = 1;
        m_pos = 0;
        if (pend_q.size() > 0) apply_pending();
      end
    end else if (!en) begin
      m_run = 0;
      m_pos = 0;
    end else if (tick) begin
      if (m_pos == m_per) begin
        m_pos = 0;
        m_pe  = 1;
        if (pend_q.size() > 0) apply_pending();
      end else begin
        m_pos = m_pos + 1;
      end
    end
    if (accept) begin
      c.per  = int'(period_in);
      c.duty = int'(duty_in);
      pend_q.push_back(c);
    end
    m_prev = div_clk;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(model_out());
    end else begin
      model_step();
      exp_q.push_back(model_out());
    end
  end

  task automatic check(input string name, input logic act, input bit expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      check("pwm_out", pwm_out, e.pwm);
      check("period_end", period_end, e.pe);
      check("running", running, e.run);
      check("cfg_ready", cfg_ready, e.rdy);
    end
  end

  // Divider emulation: toggle every div_half cycles, or a random level when div_half is 0.
  int div_half = 5;
  int div_cnt  = 0;

  task automatic drive_div();
    if (div_half == 0) begin
      div_clk = 1'($urandom_range(0, 1));
    end else begin
      div_cnt++;
      if (div_cnt >= div_half) begin
        div_cnt = 0;
        div_clk = ~div_clk;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      drive_div();
    end
  endtask

  task automatic send_cfg(input int p, input int d);
    cfg_valid = 1'b1;
    period_in = 8'(p);
    duty_in   = 8'(d);
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int hold;
    en = 1'b1;
    cyc(5);
    rst = 1'b1;
    cyc(20);

    send_cfg(3, 2);
    cyc(120);

    send_cfg(1, 1);
    cyc(100);

    cfg_valid = 1'b1;
    period_in = 8'd3;
    duty_in   = 8'd2;
    cyc(1);
    period_in = 8'd2;
    duty_in   = 8'd1;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(80);
    send_cfg(2, 1);
    cyc(80);

    send_cfg(3, 0);
    cyc(100);
    send_cfg(3, 5);
    cyc(100);
    send_cfg(0, 1);
    cyc(60);

    send_cfg(3, 2);
    cyc(57);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(80);

    cyc(13);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(10);
    send_cfg(4, 2);
    cyc(40);

    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        div_half = int'($urandom_range(0, 4));
        div_cnt  = 0;
      end
      en = ($urandom_range(0, 99) < 96);
      if (hold > 0) begin
        hold--;
        if (hold == 0) cfg_valid = 1'b0;
      end else if ($urandom_range(0, 99) < 6) begin
        cfg_valid = 1'b1;
        period_in = 8'($urandom_range(0, 7));
        duty_in   = 8'($urandom_range(0, 9));
        hold      = int'($urandom_range(1, 3));
      end
      cyc(1);
    end
    cfg_valid = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
